// File: rtl/me_pkg.sv
// Shared types and helpers for the motion-estimation best-candidate selector.
package me_pkg;

  localparam int MV_HALF_W = 7;

  typedef struct packed {
    logic [MV_HALF_W-1:0] mvx;
    logic [MV_HALF_W-1:0] mvy;
  } mv_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  // All-ones SAD of width w, right-aligned; callers truncate to their SAD width.
  function automatic logic [63:0] sad_init(input int w);
    logic [63:0] ones;
    ones = '1;
    return (w >= 64) ? ones : (ones >> (64 - w));
  endfunction

endpackage

// File: rtl/mv_min_update.sv
// Compare/replace step of a running minimum: picks cand over ref when smaller,
// or on equal SAD when later candidates win ties (TIE_KEEP_FIRST=0).
module mv_min_update
  import me_pkg::*;
#(
  parameter int SAD_W          = 16,
  parameter int MV_W           = 14,
  parameter int TIE_KEEP_FIRST = 1
) (
  input  logic [SAD_W-1:0] ref_sad,
  input  logic [MV_W-1:0]  ref_mv,
  input  logic [SAD_W-1:0] cand_sad,
  input  logic [MV_W-1:0]  cand_mv,
  input  logic             force_take,
  output logic             take,
  output logic [SAD_W-1:0] sel_sad,
  output logic [MV_W-1:0]  sel_mv
);

  always_comb begin
    take = force_take || (cand_sad < ref_sad) ||
           ((TIE_KEEP_FIRST == 0) && (cand_sad == ref_sad));
    sel_sad = take ? cand_sad : ref_sad;
    sel_mv  = take ? cand_mv  : ref_mv;
  end

endmodule

// File: rtl/mv_best_select.sv
// Streams (SAD, MV) candidates per search block and publishes the minimum per group.
// Define MV_BEST_SELECT_SECOND_EN to also track and publish the runner-up (out_sad2/out_mv2).
module mv_best_select
  import me_pkg::*;
#(
  parameter int SAD_W          = 16,
  parameter int MV_W           = 14,
  parameter int MAX_CAND       = 8,
  parameter int TIE_KEEP_FIRST = 1,
  localparam int CNT_W         = $clog2(MAX_CAND + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             cand_valid,
  output logic             cand_ready,
  input  logic [SAD_W-1:0] cand_sad,
  input  logic [MV_W-1:0]  cand_mv,
  input  logic             cand_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SAD_W-1:0] out_sad,
  output logic [MV_W-1:0]  out_mv,
  output logic [CNT_W-1:0] out_count,
`ifdef MV_BEST_SELECT_SECOND_EN
  output logic [SAD_W-1:0] out_sad2,
  output logic [MV_W-1:0]  out_mv2,
`endif
  output logic             out_overflow
);

  localparam logic [SAD_W-1:0] SAD_ONES = SAD_W'(sad_init(SAD_W));
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_CAND);

  state_e             state_q, state_d;
  logic [SAD_W-1:0]   best_sad_q, best_sad_d;
  logic [MV_W-1:0]    best_mv_q, best_mv_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [SAD_W-1:0]   out_sad_q, out_sad_d;
  logic [MV_W-1:0]    out_mv_q, out_mv_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;
  logic               out_overflow_q, out_overflow_d;

  logic               accept, in_idle, close, at_max, take_best;
  logic [CNT_W-1:0]   cnt_inc;
  logic [SAD_W-1:0]   nb_sad;
  logic [MV_W-1:0]    nb_mv;

  assign cand_ready = !out_valid_q || out_ready;
  assign accept     = cand_valid && cand_ready;
  assign in_idle    = (state_q == IDLE);
  assign cnt_inc    = in_idle ? CNT_W'(1) : cnt_q + CNT_W'(1);
  assign at_max     = (cnt_inc == CNT_MAX);
  assign close      = accept && (cand_last || at_max);

  // First candidate of a group loads unconditionally, whatever best holds.
  mv_min_update #(
    .SAD_W(SAD_W), .MV_W(MV_W), .TIE_KEEP_FIRST(TIE_KEEP_FIRST)
  ) u_best (
    .ref_sad(best_sad_q), .ref_mv(best_mv_q),
    .cand_sad(cand_sad), .cand_mv(cand_mv),
    .force_take(in_idle),
    .take(take_best), .sel_sad(nb_sad), .sel_mv(nb_mv)
  );

`ifdef MV_BEST_SELECT_SECOND_EN
  logic [SAD_W-1:0] sad2_q, sad2_d, out_sad2_q, out_sad2_d, sel2_sad, nb2_sad;
  logic [MV_W-1:0]  mv2_q, mv2_d, out_mv2_q, out_mv2_d, sel2_mv, nb2_mv;
  logic             take2;

  mv_min_update #(
    .SAD_W(SAD_W), .MV_W(MV_W), .TIE_KEEP_FIRST(TIE_KEEP_FIRST)
  ) u_second (
    .ref_sad(sad2_q), .ref_mv(mv2_q),
    .cand_sad(cand_sad), .cand_mv(cand_mv),
    .force_take(1'b0),
    .take(take2), .sel_sad(sel2_sad), .sel_mv(sel2_mv)
  );

  // A new best demotes the old best into the runner-up slot.
  always_comb begin
    if (in_idle) begin
      nb2_sad = SAD_ONES;
      nb2_mv  = '0;
    end else if (take_best) begin
      nb2_sad = best_sad_q;
      nb2_mv  = best_mv_q;
    end else begin
      nb2_sad = sel2_sad;
      nb2_mv  = sel2_mv;
    end
  end

  assign out_sad2 = out_sad2_q;
  assign out_mv2  = out_mv2_q;
`endif

  always_comb begin
    state_d        = state_q;
    best_sad_d     = best_sad_q;
    best_mv_d      = best_mv_q;
    cnt_d          = cnt_q;
    out_valid_d    = out_valid_q;
    out_sad_d      = out_sad_q;
    out_mv_d       = out_mv_q;
    out_count_d    = out_count_q;
    out_overflow_d = out_overflow_q;
`ifdef MV_BEST_SELECT_SECOND_EN
    sad2_d         = sad2_q;
    mv2_d          = mv2_q;
    out_sad2_d     = out_sad2_q;
    out_mv2_d      = out_mv2_q;
`endif

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (!flush && close) begin
      out_valid_d    = 1'b1;
      out_sad_d      = nb_sad;
      out_mv_d       = nb_mv;
      out_count_d    = cnt_inc;
      out_overflow_d = at_max && !cand_last;
`ifdef MV_BEST_SELECT_SECOND_EN
      out_sad2_d     = nb2_sad;
      out_mv2_d      = nb2_mv;
`endif
    end

    // flush wins over a simultaneous close; both leave the accumulator empty.
    if (flush || close) begin
      state_d    = IDLE;
      best_sad_d = SAD_ONES;
      best_mv_d  = '0;
      cnt_d      = '0;
`ifdef MV_BEST_SELECT_SECOND_EN
      sad2_d     = SAD_ONES;
      mv2_d      = '0;
`endif
    end else if (accept) begin
      state_d    = ACCUM;
      best_sad_d = nb_sad;
      best_mv_d  = nb_mv;
      cnt_d      = cnt_inc;
`ifdef MV_BEST_SELECT_SECOND_EN
      sad2_d     = nb2_sad;
      mv2_d      = nb2_mv;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      best_sad_q     <= SAD_ONES;
      best_mv_q      <= '0;
      cnt_q          <= '0;
      out_valid_q    <= 1'b0;
      out_sad_q      <= SAD_ONES;
      out_mv_q       <= '0;
      out_count_q    <= '0;
      out_overflow_q <= 1'b0;
`ifdef MV_BEST_SELECT_SECOND_EN
      sad2_q         <= SAD_ONES;
      mv2_q          <= '0;
      out_sad2_q     <= SAD_ONES;
      out_mv2_q      <= '0;
`endif
    end else begin
      state_q        <= state_d;
      best_sad_q     <= best_sad_d;
      best_mv_q      <= best_mv_d;
      cnt_q          <= cnt_d;
      out_valid_q    <= out_valid_d;
      out_sad_q      <= out_sad_d;
      out_mv_q       <= out_mv_d;
      out_count_q    <= out_count_d;
      out_overflow_q <= out_overflow_d;
`ifdef MV_BEST_SELECT_SECOND_EN
      sad2_q         <= sad2_d;
      mv2_q          <= mv2_d;
      out_sad2_q     <= out_sad2_d;
      out_mv2_q      <= out_mv2_d;
`endif
    end
  end

  assign out_valid    = out_valid_q;
  assign out_sad      = out_sad_q;
  assign out_mv       = out_mv_q;
  assign out_count    = out_count_q;
  assign out_overflow = out_overflow_q;

endmodule

// File: tb/tb_mv_best_select.sv
// Bench for mv_best_select: three instances (MAX_CAND 8/4/1, tie keep-first/last/first)
// share one stimulus stream and are checked against a queue-based group model.
module tb_mv_best_select;
  import me_pkg::*;

  localparam int SW = 16;
  localparam int MW = 14;
  localparam int NI = 3;
  localparam int CW_A = $clog2(9);
  localparam int CW_B = $clog2(5);
  localparam int CW_C = $clog2(2);
  localparam int ONES = 32'h0000_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0, cand_valid = 1'b0, cand_last = 1'b0, out_ready = 1'b0;
  logic [SW-1:0] cand_sad = '0;
  logic [MW-1:0] cand_mv = '0;

  logic rdy_a, rdy_b, rdy_c, ov_a, ov_b, ov_c, ovf_a, ovf_b, ovf_c;
  logic [SW-1:0] sad_a, sad_b, sad_c;
  logic [MW-1:0] mv_a, mv_b, mv_c;
  logic [CW_A-1:0] cnt_a;
  logic [CW_B-1:0] cnt_b;
  logic [CW_C-1:0] cnt_c;
`ifdef MV_BEST_SELECT_SECOND_EN
  logic [SW-1:0] sad2_a, sad2_b, sad2_c;
  logic [MW-1:0] mv2_a, mv2_b, mv2_c;
`endif

  always #5 clk = ~clk;

  mv_best_select #(.SAD_W(SW), .MV_W(MW), .MAX_CAND(8), .TIE_KEEP_FIRST(1)) dut_a (
    .clk(clk), .reset(rst), .flush(flush), .cand_valid(cand_valid), .cand_ready(rdy_a),
    .cand_sad(cand_sad), .cand_mv(cand_mv), .cand_last(cand_last),
    .out_valid(ov_a), .out_ready(out_ready), .out_sad(sad_a), .out_mv(mv_a), .out_count(cnt_a),
`ifdef MV_BEST_SELECT_SECOND_EN
    .out_sad2(sad2_a), .out_mv2(mv2_a),
`endif
    .out_overflow(ovf_a));

  mv_best_select #(.SAD_W(SW), .MV_W(MW), .MAX_CAND(4), .TIE_KEEP_FIRST(0)) dut_b (
    .clk(clk), .reset(rst), .flush(flush), .cand_valid(cand_valid), .cand_ready(rdy_b),
    .cand_sad(cand_sad), .cand_mv(cand_mv), .cand_last(cand_last),
    .out_valid(ov_b), .out_ready(out_ready), .out_sad(sad_b), .out_mv(mv_b), .out_count(cnt_b),
`ifdef MV_BEST_SELECT_SECOND_EN
    .out_sad2(sad2_b), .out_mv2(mv2_b),
`endif
    .out_overflow(ovf_b));

  mv_best_select #(.SAD_W(SW), .MV_W(MW), .MAX_CAND(1), .TIE_KEEP_FIRST(1)) dut_c (
    .clk(clk), .reset(rst), .flush(flush), .cand_valid(cand_valid), .cand_ready(rdy_c),
    .cand_sad(cand_sad), .cand_mv(cand_mv), .cand_last(cand_last),
    .out_valid(ov_c), .out_ready(out_ready), .out_sad(sad_c), .out_mv(mv_c), .out_count(cnt_c),
`ifdef MV_BEST_SELECT_SECOND_EN
    .out_sad2(sad2_c), .out_mv2(mv2_c),
`endif
    .out_overflow(ovf_c));

  int n_cmp = 0;
  int n_err = 0;

  function automatic int mc_of(int i);
    return (i == 0) ? 8 : (i == 1) ? 4 : 1;
  endfunction
  function automatic bit tk_of(int i);
    return (i != 1);
  endfunction

  task automatic chk(string nm, int inst, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s[%0d] at %0t: got %0h, expected %0h", nm, inst, $time, act, exp);
    end
  endtask

  // Reference model: the open group is a plain list of accepted candidates.
  int mq_sad[NI][$];
  int mq_mv[NI][$];
  bit m_ov[NI];
  int m_sad[NI], m_mv[NI], m_cnt[NI], m_ovf[NI], m_sad2[NI], m_mv2[NI];

  typedef struct { int sad; int mv; int cnt; int ovf; } res_t;
  res_t log_q[NI][$];

  // Index of the minimum-SAD entry (skipping excl); ties go first or last by the tie rule.
  function automatic int pick(int i, int excl);
    int minv = -1;
    int idx = -1;
    for (int j = 0; j < mq_sad[i].size(); j++)
      if (j != excl && (minv < 0 || mq_sad[i][j] < minv)) minv = mq_sad[i][j];
    for (int j = 0; j < mq_sad[i].size(); j++)
      if (j != excl && mq_sad[i][j] == minv && (idx < 0 || !tk_of(i))) idx = j;
    return idx;
  endfunction

  task automatic model_step(int i);
    bit acc;
    int n, b, s;
    acc = cand_valid && (!m_ov[i] || out_ready);
    if (m_ov[i] && out_ready) m_ov[i] = 1'b0;
    if (flush) begin
      mq_sad[i].delete();
      mq_mv[i].delete();
    end else if (acc) begin
      mq_sad[i].push_back(int'(cand_sad));
      mq_mv[i].push_back(int'(cand_mv));
      n = mq_sad[i].size();
      if (cand_last || n == mc_of(i)) begin
        b = pick(i, -1);
        s = pick(i, b);
        m_sad[i]  = mq_sad[i][b];
        m_mv[i]   = mq_mv[i][b];
        m_sad2[i] = (s < 0) ? ONES : mq_sad[i][s];
        m_mv2[i]  = (s < 0) ? 0 : mq_mv[i][s];
        m_cnt[i]  = n;
        m_ovf[i]  = (n == mc_of(i) && !cand_last) ? 1 : 0;
        m_ov[i]   = 1'b1;
        mq_sad[i].delete();
        mq_mv[i].delete();
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        m_ov[i] = 1'b0;
        mq_sad[i].delete();
        mq_mv[i].delete();
      end else begin
        model_step(i);
      end
    end
  end

  // Compare process: every cycle, away from the rising edge.
  always @(negedge clk) begin
    int d_rdy[NI], d_ov[NI], d_sad[NI], d_mv[NI], d_cnt[NI], d_ovf[NI];
    d_rdy = '{int'(rdy_a), int'(rdy_b), int'(rdy_c)};
    d_ov  = '{int'(ov_a), int'(ov_b), int'(ov_c)};
    d_sad = '{int'(sad_a), int'(sad_b), int'(sad_c)};
    d_mv  = '{int'(mv_a), int'(mv_b), int'(mv_c)};
    d_cnt = '{int'(cnt_a), int'(cnt_b), int'(cnt_c)};
    d_ovf = '{int'(ovf_a), int'(ovf_b), int'(ovf_c)};
    if (!rst) begin
      for (int i = 0; i < NI; i++) begin
        chk("cand_ready", i, d_rdy[i], (!m_ov[i] || out_ready) ? 1 : 0);
        chk("out_valid", i, d_ov[i], m_ov[i] ? 1 : 0);
        if (m_ov[i] && d_ov[i] == 1) begin
          chk("out_sad", i, d_sad[i], m_sad[i]);
          chk("out_mv", i, d_mv[i], m_mv[i]);
          chk("out_count", i, d_cnt[i], m_cnt[i]);
          chk("out_overflow", i, d_ovf[i], m_ovf[i]);
`ifdef MV_BEST_SELECT_SECOND_EN
          begin
            int d_sad2[NI], d_mv2[NI];
            d_sad2 = '{int'(sad2_a), int'(sad2_b), int'(sad2_c)};
            d_mv2  = '{int'(mv2_a), int'(mv2_b), int'(mv2_c)};
            chk("out_sad2", i, d_sad2[i], m_sad2[i]);
            if (m_sad2[i] != ONES) chk("out_mv2", i, d_mv2[i], m_mv2[i]);
          end
`endif
        end
        if (d_ov[i] == 1 && out_ready)
          log_q[i].push_back('{sad: d_sad[i], mv: d_mv[i], cnt: d_cnt[i], ovf: d_ovf[i]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    for (int i = 0; i < NI; i++) log_q[i].delete();
  endtask

  task automatic chk_log(string nm, int i, int k, int sad, int mv, int cnt, int ovf);
    chk({nm, "_present"}, i, (log_q[i].size() > k) ? 1 : 0, 1);
    if (log_q[i].size() > k) begin
      chk({nm, "_sad"}, i, log_q[i][k].sad, sad);
      chk({nm, "_mv"}, i, log_q[i][k].mv, mv);
      chk({nm, "_count"}, i, log_q[i][k].cnt, cnt);
      chk({nm, "_overflow"}, i, log_q[i][k].ovf, ovf);
    end
  endtask

  // Present one candidate and hold it until every instance can take it at the same edge.
  task automatic send(int sad, int mv, bit last);
    int k = 0;
    cand_valid = 1'b1;
    cand_sad   = SW'(sad);
    cand_mv    = MW'(mv);
    cand_last  = last;
    while (!(rdy_a && rdy_b && rdy_c) && k < 100) begin
      tick();
      k++;
    end
    if (k >= 100) chk("send_timeout", 0, 0, 1);
    tick();
    cand_valid = 1'b0;
    cand_last  = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    chk("reset_out_valid", 0, int'(ov_a), 0);
    chk("reset_out_sad", 0, int'(sad_a), ONES);
    chk("reset_out_mv", 0, int'(mv_a), 0);
    chk("reset_out_count", 0, int'(cnt_a), 0);
    chk("reset_out_overflow", 0, int'(ovf_a), 0);
    chk("reset_cand_ready", 0, int'(rdy_a), 1);
    rst = 1'b0;
    out_ready = 1'b1;
    tick();

    // Basic group, one-cycle latency
    clear_logs();
    send(300, 'h0101, 0);
    send(120, 'h0202, 0);
    chk("t1_no_early_valid", 0, int'(ov_a), 0);
    send(450, 'h0303, 1);
    chk("t1_latency_valid", 0, int'(ov_a), 1);
    chk("t1_latency_sad", 0, int'(sad_a), 120);
    repeat (3) tick();
    chk_log("t1", 0, 0, 120, 'h0202, 3, 0);
    chk_log("t1", 2, 0, 300, 'h0101, 1, 1);
    chk_log("t1_last", 2, 2, 450, 'h0303, 1, 0);

    // Ties
    clear_logs();
    send(50, 'h0A0A, 0);
    send(50, 'h0B0B, 1);
    repeat (3) tick();
    chk_log("t2_keep_first", 0, 0, 50, 'h0A0A, 2, 0);
    chk_log("t2_keep_last", 1, 0, 50, 'h0B0B, 2, 0);

    // Forced close at MAX_CAND=4 on a six-candidate group
    clear_logs();
    send(40, 'h01, 0);
    send(30, 'h02, 0);
    send(20, 'h03, 0);
    send(10, 'h04, 0);
    send(5, 'h05, 0);
    send(60, 'h06, 1);
    repeat (3) tick();
    chk_log("t3_forced", 1, 0, 10, 'h04, 4, 1);
    chk_log("t3_tail", 1, 1, 5, 'h05, 2, 0);
    chk_log("t3_wide", 0, 0, 5, 'h05, 6, 0);

    // Back-pressure: pending result stalls the next group
    clear_logs();
    out_ready = 1'b0;
    send(100, 'h0100, 1);
    cand_valid = 1'b1;
    cand_sad   = 16'd200;
    cand_mv    = 14'h0200;
    cand_last  = 1'b0;
    repeat (4) begin
      tick();
      chk("t4_stall_ready", 0, int'(rdy_a), 0);
      chk("t4_stall_sad", 0, int'(sad_a), 100);
    end
    out_ready = 1'b1;
    tick();
    cand_sad  = 16'd150;
    cand_mv   = 14'h0150;
    cand_last = 1'b1;
    tick();
    cand_valid = 1'b0;
    cand_last  = 1'b0;
    repeat (3) tick();
    chk_log("t4_first", 0, 0, 100, 'h0100, 1, 0);
    chk_log("t4_second", 0, 1, 150, 'h0150, 2, 0);
    chk("t4_single_count", 2, log_q[2].size(), 3);

    // Flush mid-group
    clear_logs();
    send(10, 'h11, 0);
    send(20, 'h22, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    send(500, 'h55, 1);
    repeat (3) tick();
    chk_log("t5_after_flush", 0, 0, 500, 'h55, 1, 0);
    chk("t5_log_size", 0, log_q[0].size(), 1);

    // Asynchronous reset mid-group and with a result pending
    send(3, 'h03, 0);
    send(4, 'h04, 0);
    rst = 1'b1;
    #1;
    chk("t6a_valid", 0, int'(ov_a), 0);
    tick();
    rst = 1'b0;
    out_ready = 1'b0;
    send(1, 'h01, 1);
    chk("t6b_pending", 0, int'(ov_a), 1);
    rst = 1'b1;
    #1;
    chk("t6b_valid_cleared", 0, int'(ov_a), 0);
    chk("t6b_sad_cleared", 0, int'(sad_a), ONES);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    clear_logs();
    send(7, 'h07, 1);
    repeat (3) tick();
    chk_log("t6_fresh", 0, 0, 7, 'h07, 1, 0);
    chk("t6_log_size", 0, log_q[0].size(), 1);

    // All-ones SAD is a legal sole candidate
    clear_logs();
    send(ONES, 'h1234, 1);
    repeat (3) tick();
    chk_log("t7_all_ones", 0, 0, ONES, 'h1234, 1, 0);

    // Random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      tick();
      rst        = ($urandom_range(0, 499) == 0);
      flush      = ($urandom_range(0, 19) == 0);
      cand_valid = ($urandom_range(0, 9) < 7);
      cand_last  = ($urandom_range(0, 3) == 0);
      out_ready  = ($urandom_range(0, 9) < 6);
      cand_sad   = ($urandom_range(0, 15) == 0) ? 16'hFFFF : SW'($urandom_range(0, 20));
      cand_mv    = MW'($urandom);
    end
    tick();
    rst        = 1'b0;
    flush      = 1'b0;
    cand_valid = 1'b0;
    out_ready  = 1'b1;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mv_best_select.md
Name: mv_best_select

Overview:
- Parametrised successor to the three-candidate motion-vector selector in the motion-estimation back end.
- Accepts a stream of (SAD, MV) candidates grouped per search block. Tracks a running minimum, so no candidate storage array is needed.
- Emits the best MV/SAD per group through a valid/ready output register.
- Sits between the SAD adder tree and the MV write-back / entropy-coder interface.

Parameters:
SAD_W, 16, SAD width in bits (unsigned)
MV_W, 14, packed MV width {mvx[MV_W/2-1:0], mvy[MV_W/2-1:0]}, two's complement halves
MAX_CAND, 8, maximum candidates per group before forced close (>=1)
TIE_KEEP_FIRST, 1, 1: equal SAD keeps earlier candidate; 0: equal SAD takes later candidate
CNT_W, $clog2(MAX_CAND+1), candidate-count width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
flush  in  1  synchronous abort of the group in progress
cand_valid  in  1  candidate present this cycle
cand_ready  out  1  candidate accepted when cand_valid & cand_ready
cand_sad  in  SAD_W  candidate SAD
cand_mv  in  MV_W  candidate MV, aligned with cand_sad (no internal delay)
cand_last  in  1  final candidate of group
out_valid  out  1  result register holds an unconsumed result
out_ready  in  1  downstream accepts result
out_sad  out  SAD_W  minimum SAD of group
out_mv  out  MV_W  MV of minimum
out_count  out  CNT_W  candidates accepted in group
out_overflow  out  1  group was force-closed at MAX_CAND

Behaviour:
- Reset values:
  - Outputs: out_valid=0, out_sad=all-ones, out_mv=0, out_count=0, out_overflow=0.
  - Accumulator: best_sad=all-ones, best_mv=0, cnt=0.
  - State: IDLE.
- cand_ready = !out_valid | out_ready. This is combinational from out_ready; there is no other combinational in-to-out path.
- Accepted candidate = cand_valid & cand_ready.
- States:
  - IDLE: no candidates in group. An accepted candidate loads best_sad/best_mv unconditionally, sets cnt=1, moves to ACCUM. If it is also a close event, the result is published directly and the state stays IDLE.
  - ACCUM: an accepted candidate replaces best when cand_sad < best_sad. It also replaces on equality when TIE_KEEP_FIRST=0. cnt increments.
- Close event = accepted candidate with cand_last=1, or accepted candidate making cnt==MAX_CAND.
- On a close event:
  - The following edge loads out_sad/out_mv with the min including the closing candidate.
  - out_count gets the final cnt; out_overflow = (forced close & !cand_last).
  - out_valid is set, and the accumulator returns to IDLE.
  - Latency: closing candidate to out_valid = 1 cycle.
- The output holds stable while out_valid & !out_ready. out_valid clears on handshake unless a new close occurs in the same cycle; a new close reloads the result and keeps out_valid=1 (back-to-back groups, 1 result/cycle).
- Stall: while cand_ready=0, candidates are neither accepted nor compared. The accumulator state is frozen.
- flush:
  - Clears the accumulator to IDLE (cnt=0, best_sad=all-ones) the next edge. Any candidate in the same cycle is dropped.
  - A pending output result is unaffected.
  - flush has priority over a simultaneous close.
- SAD compare is unsigned, full SAD_W. An all-ones SAD is a legal candidate and is selected if it is the only one.
- MAX_CAND=1: every candidate closes its own group.
- Reset mid-group or mid-handshake: everything returns to reset values immediately (asynchronous). No partial result is emitted.

Optional Feature:
- Macro: MV_BEST_SELECT_SECOND_EN.
- Defined:
  - Adds outputs out_sad2 (SAD_W) and out_mv2 (MV_W), holding the runner-up of the group.
  - Tracked via second running register: a new best demotes the old best; otherwise cand_sad < sad2 replaces second. Tie rule follows TIE_KEEP_FIRST.
  - Single-candidate group: out_sad2=all-ones, out_mv2=0. Reset values are the same.
- Undefined: ports and logic absent; all behaviour above is unchanged.

Decomposition:
- Package me_pkg: SAD_INIT (all-ones) helper function, MV packing typedef mv_t {mvx, mvy}, state enum {IDLE, ACCUM}.
- One sub-module: mv_min_update. Combinational compare/replace of (best, cand) with the TIE_KEEP_FIRST rule; instantiated twice when MV_BEST_SELECT_SECOND_EN is defined.

Test Plan:
- Reset, group SAD {300,120,450}, MVs {0x0101,0x0202,0x0303}, last on 3rd → 1 cycle later out_valid=1, out_sad=120, out_mv=0x0202, out_count=3, out_overflow=0.
- Tie: SAD {50,50}, MVs {A,B}; TIE_KEEP_FIRST=1 → out_mv=A, TIE_KEEP_FIRST=0 → out_mv=B.
- MAX_CAND=4, 6 candidates, cand_last only on 6th → two results: count=4 with overflow=1, then count=2 with overflow=0.
- out_ready=0 with result pending, next group streams → cand_ready=0, out_* stable. Raise out_ready → both groups' results arrive in order, none lost.
- flush after 2 candidates {10,20}, then group {500} last → out_sad=500, out_count=1.
- Assert reset mid-group and during a pending result → out_valid=0 immediately. A fresh group {7} then yields out_sad=7.
